// File: rtl/ht_out_buffer.sv
// ht_out_buffer: collects one timestep of 8-bit h_t elements from the LSTM
// datapath, packs them four per 32-bit word, and exposes them to a bus reader
// until software acknowledges with rd_done_i.
//
// Optional feature macro: HTBUF_CLEAR_ON_DONE_EN
//   defined   -> all buffer words zero on the rd_done_i edge that leaves READY
//   undefined -> buffer words persist and are only overwritten by accepts
module ht_out_buffer #(
    parameter int unsigned N_ELEM = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ht_valid_i,
    input  logic [7:0]  ht_data_i,
    input  logic        ht_last_i,
    output logic        ht_ready_o,
    input  logic        rd_req_i,
    input  logic [2:0]  rd_idx_i,
    output logic        rd_rvalid_o,
    output logic [31:0] rd_rdata_o,
    output logic        w_valid_o,
    input  logic        rd_done_i,
    output logic [5:0]  elem_cnt_o,
    output logic        overflow_o
);

    localparam int unsigned N_WORD = N_ELEM / 4;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   buf_q [N_WORD];
    logic [WORD_W-1:0]   buf_d [N_WORD];
    logic                ovf_q, ovf_d;
    logic                rvalid_q, rvalid_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic                w_valid_q, w_valid_d;
    logic                ht_ready_q, ht_ready_d;
    logic                accept_c;

    // Next-state, buffer write, overflow and read-port logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        ovf_d      = ovf_q;
        rvalid_d   = rd_req_i;
        rdata_d    = rdata_q;
        accept_c   = ht_valid_i & ht_ready_q;

        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (accept_c) begin
                    for (int w = 0; w < int'(N_WORD); w++) begin
                        if (int'(cnt_q[CNT_W-1:2]) == w) begin
                            buf_d[w][int'(cnt_q[1:0]) * 8 +: BYTE_W] = ht_data_i;
                        end
                    end
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    if (ht_last_i || (cnt_d == CNT_W'(N_ELEM))) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_READY: begin
                // Elements offered while full are dropped and flagged
                if (ht_valid_i) begin
                    ovf_d = 1'b1;
                end
                // Acknowledge wins over a same-cycle drop
                if (rd_done_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
`ifdef HTBUF_CLEAR_ON_DONE_EN
                    for (int w = 0; w < int'(N_WORD); w++) begin
                        buf_d[w] = '0;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reads see the pre-write buffer; out-of-range indices return zero
        if (rd_req_i) begin
            rdata_d = '0;
            for (int w = 0; w < int'(N_WORD); w++) begin
                if (int'(rd_idx_i) == w) begin
                    rdata_d = buf_q[w];
                end
            end
        end

        w_valid_d  = (state_d == ST_READY);
        ht_ready_d = (state_d != ST_READY);
    end

    // State, buffer and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            w_valid_q  <= 1'b0;
            ht_ready_q <= 1'b1;
            for (int w = 0; w < int'(N_WORD); w++) begin
                buf_q[w] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            w_valid_q  <= w_valid_d;
            ht_ready_q <= ht_ready_d;
            for (int w = 0; w < int'(N_WORD); w++) begin
                buf_q[w] <= buf_d[w];
            end
        end
    end

    assign ht_ready_o  = ht_ready_q;
    assign rd_rvalid_o = rvalid_q;
    assign rd_rdata_o  = rdata_q;
    assign w_valid_o   = w_valid_q;
    assign elem_cnt_o  = cnt_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_ht_out_buffer.sv
// Directed testbench for ht_out_buffer: default 32-element instance plus an
// 8-element instance used to reach an out-of-range read index.
module tb_ht_out_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ht_valid, ht_last, ht_ready;
    logic [7:0]  ht_data;
    logic        rd_req, rd_rvalid, w_valid, rd_done, overflow;
    logic [2:0]  rd_idx;
    logic [31:0] rd_rdata;
    logic [5:0]  elem_cnt;

    logic        s_valid, s_last, s_ready;
    logic [7:0]  s_data;
    logic        s_rd_req, s_rvalid, s_w_valid, s_rd_done, s_overflow;
    logic [2:0]  s_rd_idx;
    logic [31:0] s_rdata;
    logic [5:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_w1, exp_w2;

    always #5 clk = ~clk;

    ht_out_buffer #(.N_ELEM(32)) dut (
        .clk(clk), .rst(rst),
        .ht_valid_i(ht_valid), .ht_data_i(ht_data), .ht_last_i(ht_last),
        .ht_ready_o(ht_ready),
        .rd_req_i(rd_req), .rd_idx_i(rd_idx),
        .rd_rvalid_o(rd_rvalid), .rd_rdata_o(rd_rdata),
        .w_valid_o(w_valid), .rd_done_i(rd_done),
        .elem_cnt_o(elem_cnt), .overflow_o(overflow)
    );

    ht_out_buffer #(.N_ELEM(8)) dut_s (
        .clk(clk), .rst(rst),
        .ht_valid_i(s_valid), .ht_data_i(s_data), .ht_last_i(s_last),
        .ht_ready_o(s_ready),
        .rd_req_i(s_rd_req), .rd_idx_i(s_rd_idx),
        .rd_rvalid_o(s_rvalid), .rd_rdata_o(s_rdata),
        .w_valid_o(s_w_valid), .rd_done_i(s_rd_done),
        .elem_cnt_o(s_cnt), .overflow_o(s_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic last);
        ht_valid = 1'b1; ht_data = d; ht_last = last;
        tick();
        ht_valid = 1'b0; ht_last = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx);
        rd_req = 1'b1; rd_idx = idx;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic done();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({w_valid, elem_cnt, overflow, rd_rvalid, rd_rdata, ht_ready} !==
            {1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state got wv=%b cnt=%0d ovf=%b rv=%b rd=%h rdy=%b exp 0 0 0 0 0 1",
                     w_valid, elem_cnt, overflow, rd_rvalid, rd_rdata, ht_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < 31; i++) push(8'(i), 1'b0);
        total++;
        if ({w_valid, elem_cnt, ht_ready} !== {1'b0, 6'd31, 1'b1}) begin
            bad++;
            $display("FAIL fill_31 got wv=%b cnt=%0d rdy=%b exp 0 31 1", w_valid, elem_cnt, ht_ready);
        end
        push(8'h1F, 1'b1);
        total++;
        if ({w_valid, elem_cnt, ht_ready} !== {1'b1, 6'd32, 1'b0}) begin
            bad++;
            $display("FAIL fill_32 got wv=%b cnt=%0d rdy=%b exp 1 32 0", w_valid, elem_cnt, ht_ready);
        end
        rd(3'd0);
        total++;
        if ({rd_rvalid, rd_rdata} !== {1'b1, 32'h03020100}) begin
            bad++;
            $display("FAIL full_rd0 got rv=%b rd=%h exp 1 03020100", rd_rvalid, rd_rdata);
        end
        tick();
        total++;
        if ({rd_rvalid, rd_rdata} !== {1'b0, 32'h03020100}) begin
            bad++;
            $display("FAIL rdata_hold got rv=%b rd=%h exp 0 03020100", rd_rvalid, rd_rdata);
        end
        rd(3'd7);
        total++;
        if ({rd_rvalid, rd_rdata} !== {1'b1, 32'h1F1E1D1C}) begin
            bad++;
            $display("FAIL full_rd7 got rv=%b rd=%h exp 1 1f1e1d1c", rd_rvalid, rd_rdata);
        end
    endtask

    task automatic test_overflow();
        ht_valid = 1'b1; ht_data = 8'h55;
        tick();
        ht_valid = 1'b0;
        total++;
        if ({overflow, elem_cnt, w_valid} !== {1'b1, 6'd32, 1'b1}) begin
            bad++;
            $display("FAIL ovf_set got ovf=%b cnt=%0d wv=%b exp 1 32 1", overflow, elem_cnt, w_valid);
        end
        rd(3'd0);
        total++;
        if (rd_rdata !== 32'h03020100) begin
            bad++;
            $display("FAIL ovf_rd0 got %h exp 03020100", rd_rdata);
        end
        rd(3'd7);
        total++;
        if ({rd_rdata, overflow} !== {32'h1F1E1D1C, 1'b1}) begin
            bad++;
            $display("FAIL ovf_rd7 got rd=%h ovf=%b exp 1f1e1d1c 1", rd_rdata, overflow);
        end
        done();
        total++;
        if ({w_valid, overflow, elem_cnt, ht_ready} !== {1'b0, 1'b0, 6'd0, 1'b1}) begin
            bad++;
            $display("FAIL ovf_done got wv=%b ovf=%b cnt=%0d rdy=%b exp 0 0 0 1",
                     w_valid, overflow, elem_cnt, ht_ready);
        end
    endtask

    task automatic test_early_last();
        for (int i = 0; i < 32; i++) push(8'hAA, 1'b0);
        total++;
        if ({w_valid, elem_cnt} !== {1'b1, 6'd32}) begin
            bad++;
            $display("FAIL count_full got wv=%b cnt=%0d exp 1 32", w_valid, elem_cnt);
        end
        ht_valid = 1'b1; ht_data = 8'h99; rd_done = 1'b1;
        tick();
        ht_valid = 1'b0; rd_done = 1'b0;
        total++;
        if ({w_valid, overflow, elem_cnt} !== {1'b0, 1'b0, 6'd0}) begin
            bad++;
            $display("FAIL done_drop got wv=%b ovf=%b cnt=%0d exp 0 0 0", w_valid, overflow, elem_cnt);
        end
        push(8'h11, 1'b0);
        push(8'h11, 1'b0);
        done();
        total++;
        if ({w_valid, elem_cnt, ht_ready} !== {1'b0, 6'd2, 1'b1}) begin
            bad++;
            $display("FAIL done_in_fill got wv=%b cnt=%0d rdy=%b exp 0 2 1", w_valid, elem_cnt, ht_ready);
        end
        push(8'h11, 1'b0);
        push(8'h11, 1'b0);
        push(8'h11, 1'b1);
        total++;
        if ({w_valid, elem_cnt} !== {1'b1, 6'd5}) begin
            bad++;
            $display("FAIL early_last got wv=%b cnt=%0d exp 1 5", w_valid, elem_cnt);
        end
`ifdef HTBUF_CLEAR_ON_DONE_EN
        exp_w1 = 32'h00000011;
        exp_w2 = 32'h00000000;
`else
        exp_w1 = 32'hAAAAAA11;
        exp_w2 = 32'hAAAAAAAA;
`endif
        rd(3'd0);
        total++;
        if (rd_rdata !== 32'h11111111) begin
            bad++;
            $display("FAIL early_rd0 got %h exp 11111111", rd_rdata);
        end
        rd(3'd1);
        total++;
        if (rd_rdata !== exp_w1) begin
            bad++;
            $display("FAIL early_rd1 got %h exp %h", rd_rdata, exp_w1);
        end
        rd(3'd2);
        total++;
        if (rd_rdata !== exp_w2) begin
            bad++;
            $display("FAIL early_rd2 got %h exp %h", rd_rdata, exp_w2);
        end
        done();
    endtask

    task automatic test_reset_mid_fill();
        for (int i = 0; i < 10; i++) push(8'(8'h40 + i), 1'b0);
        rd(3'd0);
        total++;
        if ({rd_rvalid, rd_rdata, elem_cnt} !== {1'b1, 32'h43424140, 6'd10}) begin
            bad++;
            $display("FAIL pre_reset got rv=%b rd=%h cnt=%0d exp 1 43424140 10", rd_rvalid, rd_rdata, elem_cnt);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({w_valid, elem_cnt, overflow, rd_rvalid, rd_rdata, ht_ready} !==
            {1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 1'b1}) begin
            bad++;
            $display("FAIL async_reset got wv=%b cnt=%0d ovf=%b rv=%b rd=%h rdy=%b exp 0 0 0 0 0 1",
                     w_valid, elem_cnt, overflow, rd_rvalid, rd_rdata, ht_ready);
        end
        tick();
        rst = 1'b0;
        push(8'hC5, 1'b1);
        total++;
        if ({w_valid, elem_cnt} !== {1'b1, 6'd1}) begin
            bad++;
            $display("FAIL post_reset_frame got wv=%b cnt=%0d exp 1 1", w_valid, elem_cnt);
        end
        rd(3'd0);
        total++;
        if (rd_rdata !== 32'h000000C5) begin
            bad++;
            $display("FAIL post_reset_rd0 got %h exp 000000c5", rd_rdata);
        end
        rd(3'd2);
        total++;
        if (rd_rdata !== 32'h0) begin
            bad++;
            $display("FAIL post_reset_rd2 got %h exp 00000000", rd_rdata);
        end
        done();
    endtask

    task automatic test_collision();
        for (int i = 0; i < 8; i++) push(8'h01, 1'b0);
        ht_valid = 1'b1; ht_data = 8'h77; rd_req = 1'b1; rd_idx = 3'd2;
        tick();
        ht_valid = 1'b0; rd_req = 1'b0;
        total++;
        if ({rd_rvalid, rd_rdata, elem_cnt} !== {1'b1, 32'h0, 6'd9}) begin
            bad++;
            $display("FAIL collide_rd got rv=%b rd=%h cnt=%0d exp 1 00000000 9", rd_rvalid, rd_rdata, elem_cnt);
        end
        rd(3'd2);
        total++;
        if (rd_rdata !== 32'h00000077) begin
            bad++;
            $display("FAIL collide_reread got %h exp 00000077", rd_rdata);
        end
        push(8'h02, 1'b1);
        total++;
        if ({w_valid, elem_cnt} !== {1'b1, 6'd10}) begin
            bad++;
            $display("FAIL collide_last got wv=%b cnt=%0d exp 1 10", w_valid, elem_cnt);
        end
        done();
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 8'(8'hE0 + i);
            tick();
        end
        s_valid = 1'b0;
        total++;
        if ({s_w_valid, s_cnt, s_ready} !== {1'b1, 6'd8, 1'b0}) begin
            bad++;
            $display("FAIL small_full got wv=%b cnt=%0d rdy=%b exp 1 8 0", s_w_valid, s_cnt, s_ready);
        end
        s_rd_req = 1'b1; s_rd_idx = 3'd1;
        tick();
        s_rd_req = 1'b0;
        total++;
        if ({s_rvalid, s_rdata} !== {1'b1, 32'hE7E6E5E4}) begin
            bad++;
            $display("FAIL small_rd1 got rv=%b rd=%h exp 1 e7e6e5e4", s_rvalid, s_rdata);
        end
        s_rd_req = 1'b1; s_rd_idx = 3'd5;
        tick();
        s_rd_req = 1'b0;
        total++;
        if ({s_rvalid, s_rdata} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL oor_rd got rv=%b rd=%h exp 1 00000000", s_rvalid, s_rdata);
        end
        tick();
        total++;
        if ({s_rvalid, s_rdata} !== {1'b0, 32'h0}) begin
            bad++;
            $display("FAIL oor_pulse got rv=%b rd=%h exp 0 00000000", s_rvalid, s_rdata);
        end
    endtask

    initial begin
        rst = 1'b1;
        ht_valid = 1'b0; ht_data = '0; ht_last = 1'b0;
        rd_req = 1'b0; rd_idx = '0; rd_done = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        s_rd_req = 1'b0; s_rd_idx = '0; s_rd_done = 1'b0;
        test_reset();
        test_full_frame();
        test_overflow();
        test_early_last();
        test_reset_mid_fill();
        test_collision();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
